// File: rtl/cpu_exc_pkg.sv
// Shared exception-controller types: trap FSM states, cause codes and the
// decode-legality check for the pipelined CPU's instruction set.
package cpu_exc_pkg;

  typedef enum logic [1:0] {
    USER   = 2'd0,
    ENTER  = 2'd1,
    KERNEL = 2'd2
  } exc_state_e;

  localparam logic [3:0] CAUSE_NONE     = 4'd0;
  localparam logic [3:0] CAUSE_UND      = 4'd1;
  localparam logic [3:0] CAUSE_IRQ_BASE = 4'd2;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_IMM_LO  = 6'h01;
  localparam logic [5:0] OP_IMM_HI  = 6'h0C;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_SLL    = 6'h00;
  localparam logic [5:0] FN_SRL    = 6'h02;
  localparam logic [5:0] FN_SRA    = 6'h03;
  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [5:0] FN_JALR   = 6'h09;
  localparam logic [5:0] FN_ALU_LO = 6'h20;
  localparam logic [5:0] FN_ALU_HI = 6'h27;
  localparam logic [5:0] FN_SLT    = 6'h2A;

  function automatic logic instr_legal(input logic [5:0] op, input logic [5:0] fn);
    if (op == OP_SPECIAL)
      return (fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA) || (fn == FN_JR) ||
             (fn == FN_JALR) || (fn == FN_SLT) || ((fn >= FN_ALU_LO) && (fn <= FN_ALU_HI));
    return ((op >= OP_IMM_LO) && (op <= OP_IMM_HI)) ||
           (op == OP_LUI) || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-bit 2-flop synchroniser followed by a rising-edge detector for
// asynchronous level interrupt lines.
module irq_sync_edge #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] meta_q, sync_q, prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/exc_irq_ctrl.sv
// Exception/interrupt controller: pending/mask handling, undefined-opcode
// traps and USER/ENTER/KERNEL sequencing. Define EXC_IRQ_MASK_EN for the mask register.
module exc_irq_ctrl
  import cpu_exc_pkg::*;
#(
  parameter int unsigned N_IRQ   = 4,
  parameter logic [31:0] VEC_IRQ = 32'h8000_0004,
  parameter logic [31:0] VEC_UND = 32'h8000_0008
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic             instr_valid_i,
  input  logic [31:0]      pc_i,
  input  logic [5:0]       opcode_i,
  input  logic [5:0]       funct_i,
  input  logic             eret_i,
  input  logic             ack_we_i,
  input  logic [N_IRQ-1:0] ack_data_i,
  input  logic             mask_we_i,
  input  logic [N_IRQ-1:0] mask_data_i,
  output logic             redirect_o,
  output logic [31:0]      redirect_pc_o,
  output logic             flush_o,
  output logic             kernel_o,
  output logic [31:0]      epc_o,
  output logic [3:0]       cause_o,
  output logic [N_IRQ-1:0] pending_o
);

  logic [N_IRQ-1:0] irq_rise, irq_mask, eligible;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic             irq_hit;
  logic [3:0]       irq_line;

  exc_state_e  state_q;
  logic        redirect_q, flush_q, kernel_q;
  logic [31:0] redirect_pc_q, epc_q;
  logic [3:0]  cause_q;

  irq_sync_edge #(.WIDTH(N_IRQ)) u_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (irq_i),
    .rise_o  (irq_rise)
  );

`ifdef EXC_IRQ_MASK_EN
  logic [N_IRQ-1:0] mask_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          mask_q <= '0;
    else if (mask_we_i) mask_q <= mask_data_i;
  end

  assign irq_mask = mask_q;
`else
  logic unused_mask;
  assign unused_mask = mask_we_i ^ (^mask_data_i);
  assign irq_mask    = '0;
`endif

  // A new edge is ORed in after the ack clear so that set wins.
  always_comb begin
    pending_d = pending_q;
    if (ack_we_i) pending_d = pending_d & ~ack_data_i;
    pending_d = pending_d | irq_rise;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  assign eligible = pending_q & ~irq_mask;

  always_comb begin
    irq_hit  = 1'b0;
    irq_line = '0;
    for (int unsigned k = 0; k < N_IRQ; k++) begin
      if (eligible[k] && !irq_hit) begin
        irq_hit  = 1'b1;
        irq_line = 4'(k);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= USER;
      redirect_q    <= 1'b0;
      flush_q       <= 1'b0;
      kernel_q      <= 1'b0;
      redirect_pc_q <= '0;
      epc_q         <= '0;
      cause_q       <= CAUSE_NONE;
    end else begin
      redirect_q <= 1'b0;
      flush_q    <= 1'b0;
      unique case (state_q)
        USER: begin
          if (instr_valid_i) begin
            if (irq_hit) begin
              state_q       <= ENTER;
              cause_q       <= CAUSE_IRQ_BASE + irq_line;
              epc_q         <= pc_i;
              redirect_pc_q <= VEC_IRQ;
              redirect_q    <= 1'b1;
              flush_q       <= 1'b1;
            end else if (!instr_legal(opcode_i, funct_i)) begin
              state_q       <= ENTER;
              cause_q       <= CAUSE_UND;
              epc_q         <= pc_i + 32'd4;
              redirect_pc_q <= VEC_UND;
              redirect_q    <= 1'b1;
              flush_q       <= 1'b1;
            end
          end
        end
        ENTER: begin
          state_q  <= KERNEL;
          kernel_q <= 1'b1;
        end
        KERNEL: begin
          if (instr_valid_i && eret_i) begin
            state_q       <= USER;
            kernel_q      <= 1'b0;
            redirect_q    <= 1'b1;
            redirect_pc_q <= epc_q;
            cause_q       <= CAUSE_NONE;
          end
        end
        default: state_q <= USER;
      endcase
    end
  end

  assign redirect_o    = redirect_q;
  assign flush_o       = flush_q;
  assign kernel_o      = kernel_q;
  assign redirect_pc_o = redirect_pc_q;
  assign epc_o         = epc_q;
  assign cause_o       = cause_q;
  assign pending_o     = pending_q;

endmodule

// File: tb/tb_exc_irq_ctrl.sv
// Self-checking bench for exc_irq_ctrl: directed scenarios followed by random
// traffic, all compared against an edge-by-edge behavioural model.
module tb_exc_irq_ctrl;

  localparam int          N  = 4;
  localparam logic [31:0] VI = 32'h8000_0004;
  localparam logic [31:0] VU = 32'h8000_0008;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  irq_i, ack_data_i, mask_data_i;
  logic          instr_valid_i, eret_i, ack_we_i, mask_we_i;
  logic [31:0]   pc_i;
  logic [5:0]    opcode_i, funct_i;
  logic          redirect_o, flush_o, kernel_o;
  logic [31:0]   redirect_pc_o, epc_o;
  logic [3:0]    cause_o;
  logic [N-1:0]  pending_o;

  exc_irq_ctrl #(.N_IRQ(N), .VEC_IRQ(VI), .VEC_UND(VU)) dut (
    .clk           (clk),
    .reset         (reset),
    .irq_i         (irq_i),
    .instr_valid_i (instr_valid_i),
    .pc_i          (pc_i),
    .opcode_i      (opcode_i),
    .funct_i       (funct_i),
    .eret_i        (eret_i),
    .ack_we_i      (ack_we_i),
    .ack_data_i    (ack_data_i),
    .mask_we_i     (mask_we_i),
    .mask_data_i   (mask_data_i),
    .redirect_o    (redirect_o),
    .redirect_pc_o (redirect_pc_o),
    .flush_o       (flush_o),
    .kernel_o      (kernel_o),
    .epc_o         (epc_o),
    .cause_o       (cause_o),
    .pending_o     (pending_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: mode flags, expected outputs, and the irq sample history.
  bit           m_enter, m_kern;
  logic         m_redir, m_flush, m_kflag;
  logic [31:0]  m_epc, m_rpc;
  logic [3:0]   m_cause;
  logic [N-1:0] m_pend, m_mask, h1, h2, h3;

  function automatic bit ref_legal(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) return fn inside {6'h00, 6'h02, 6'h03, 6'h08, 6'h09, [6'h20:6'h27], 6'h2A};
    return op inside {[6'h01:6'h0C], 6'h0F, 6'h23, 6'h2B};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_enter = 0; m_kern = 0;
    m_redir = 0; m_flush = 0; m_kflag = 0;
    m_epc = '0; m_rpc = '0; m_cause = '0;
    m_pend = '0; m_mask = '0; h1 = '0; h2 = '0; h3 = '0;
  endtask

  task automatic model_edge();
    logic [N-1:0] elig, rise;
    int k;
    elig = m_pend & ~m_mask;
    k = -1;
    for (int i = N - 1; i >= 0; i--) if (elig[i]) k = i;
    m_redir = 0;
    m_flush = 0;
    if (m_enter) begin
      m_enter = 0; m_kern = 1; m_kflag = 1;
    end else if (m_kern) begin
      if (instr_valid_i && eret_i) begin
        m_kern = 0; m_kflag = 0; m_redir = 1; m_rpc = m_epc; m_cause = 0;
      end
    end else if (instr_valid_i) begin
      if (k >= 0) begin
        m_enter = 1; m_cause = 4'(2 + k); m_epc = pc_i; m_rpc = VI;
        m_redir = 1; m_flush = 1;
      end else if (!ref_legal(opcode_i, funct_i)) begin
        m_enter = 1; m_cause = 4'd1; m_epc = pc_i + 32'd4; m_rpc = VU;
        m_redir = 1; m_flush = 1;
      end
    end
    rise = h2 & ~h3;
    h3 = h2; h2 = h1; h1 = irq_i;
    m_pend = (m_pend & ~(ack_we_i ? ack_data_i : '0)) | rise;
`ifdef EXC_IRQ_MASK_EN
    if (mask_we_i) m_mask = mask_data_i;
`endif
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".redirect"}, 32'(redirect_o), 32'(m_redir));
    chk({ph, ".flush"},    32'(flush_o),    32'(m_flush));
    chk({ph, ".kernel"},   32'(kernel_o),   32'(m_kflag));
    chk({ph, ".rpc"},      redirect_pc_o,   m_rpc);
    chk({ph, ".epc"},      epc_o,           m_epc);
    chk({ph, ".cause"},    32'(cause_o),    32'(m_cause));
    chk({ph, ".pending"},  32'(pending_o),  32'(m_pend));
  endtask

  task automatic tick(input string ph);
    @(posedge clk);
    model_edge();
    #1;
    check_all(ph);
  endtask

  task automatic instr(input logic v, input logic [31:0] pc, input logic [5:0] op, input logic e);
    instr_valid_i = v; pc_i = pc; opcode_i = op; funct_i = 6'h00; eret_i = e;
  endtask

  initial begin
    reset = 1'b1;
    irq_i = '0; ack_we_i = 0; ack_data_i = '0; mask_we_i = 0; mask_data_i = '0;
    instr(0, 32'h0, 6'h23, 0);
    model_reset();
    #12;
    check_all("reset");
    chk("reset.pending_zero", 32'(pending_o), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // IRQ line 2 with a steady legal instruction stream.
    instr(1, 32'h0000_0100, 6'h23, 0);
    tick("t1.idle");
    irq_i = 4'b0100;
    tick("t1.s1");
    tick("t1.s2");
    tick("t1.s3");
    chk("t1.pending_after3", 32'(pending_o), 32'h4);
    tick("t1.trap");
    chk("t1.redirect", 32'(redirect_o), 32'h1);
    chk("t1.vec", redirect_pc_o, 32'h8000_0004);
    chk("t1.epc", epc_o, 32'h100);
    chk("t1.cause", 32'(cause_o), 32'h4);
    tick("t1.enter");
    chk("t1.kernel", 32'(kernel_o), 32'h1);

    // Undefined opcode in KERNEL is ignored.
    instr(1, 32'h0000_0200, 6'h3F, 0);
    tick("t2.kund");
    tick("t2.kund2");
    chk("t2.no_redirect", 32'(redirect_o), 32'h0);

    // ERET, then the still-pending IRQ is retaken.
    instr(1, 32'h0000_0300, 6'h23, 1);
    tick("t3.eret");
    chk("t3.eret_redirect", 32'(redirect_o), 32'h1);
    chk("t3.eret_pc", redirect_pc_o, 32'h100);
    chk("t3.eret_kernel", 32'(kernel_o), 32'h0);
    chk("t3.eret_cause", 32'(cause_o), 32'h0);
    instr(1, 32'h0000_0104, 6'h23, 0);
    tick("t3.retake");
    chk("t3.retake_cause", 32'(cause_o), 32'h4);
    tick("t3.enter");
    ack_we_i = 1; ack_data_i = 4'b0100;
    instr(1, 32'h0, 6'h00, 1);
    tick("t3.ack_eret");
    ack_we_i = 0;

    // Undefined instruction in USER.
    instr(1, 32'h0000_0200, 6'h3F, 0);
    tick("t4.und");
    chk("t4.vec", redirect_pc_o, 32'h8000_0008);
    chk("t4.epc", epc_o, 32'h204);
    chk("t4.cause", 32'(cause_o), 32'h1);
    instr(0, 32'h0, 6'h23, 0);
    tick("t4.enter");
    instr(1, 32'h0, 6'h23, 1);
    tick("t4.eret");

    // IRQ beats undefined; lowest line wins.
    instr(0, 32'h0, 6'h23, 0);
    irq_i = 4'b0111;
    for (int i = 0; i < 4; i++) tick("t5.wait");
    chk("t5.pending", 32'(pending_o), 32'h3);
    instr(1, 32'h0000_0300, 6'h3F, 0);
    tick("t5.trap");
    chk("t5.cause", 32'(cause_o), 32'h2);
    chk("t5.epc", epc_o, 32'h300);
    instr(0, 32'h0, 6'h23, 0);
    tick("t5.enter");
    ack_we_i = 1; ack_data_i = '1;
    instr(1, 32'h0, 6'h23, 1);
    tick("t5.eret");
    ack_we_i = 0;

    // Ack and a new edge landing on the same clock: set wins.
    instr(0, 32'h0, 6'h23, 0);
    irq_i = 4'b0000;
    for (int i = 0; i < 3; i++) tick("t6.low");
    irq_i = 4'b0001;
    tick("t6.s1");
    tick("t6.s2");
    ack_we_i = 1; ack_data_i = 4'b0001;
    tick("t6.s3");
    ack_we_i = 0;
    chk("t6.set_wins", 32'(pending_o), 32'h1);
    ack_we_i = 1; ack_data_i = '1;
    tick("t6.clr");
    ack_we_i = 0;

`ifdef EXC_IRQ_MASK_EN
    // Masked line stays pending without trapping until unmasked.
    irq_i = 4'b0000;
    mask_we_i = 1; mask_data_i = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick("t7.low");
      mask_we_i = 0;
    end
    irq_i = 4'b0001;
    instr(1, 32'h0000_0400, 6'h23, 0);
    for (int i = 0; i < 5; i++) tick("t7.masked");
    chk("t7.pending", 32'(pending_o), 32'h1);
    chk("t7.no_trap", 32'(redirect_o), 32'h0);
    mask_we_i = 1; mask_data_i = 4'b0000;
    tick("t7.unmask");
    mask_we_i = 0;
    tick("t7.trap");
    chk("t7.cause", 32'(cause_o), 32'h2);
    instr(0, 32'h0, 6'h23, 0);
    tick("t7.enter");
    ack_we_i = 1; ack_data_i = '1;
    instr(1, 32'h0, 6'h23, 1);
    tick("t7.eret");
    ack_we_i = 0;
`endif

    // Reset while in ENTER.
    instr(1, 32'h0000_0500, 6'h3F, 0);
    tick("t8.trap");
    instr(0, 32'h0, 6'h23, 0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("t8.reset");
    chk("t8.redirect_dropped", 32'(redirect_o), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    instr(1, 32'h0000_0600, 6'h23, 0);
    tick("t8.user");
    chk("t8.kernel_user", 32'(kernel_o), 32'h0);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      logic [5:0] legal_ops [6];
      legal_ops = '{6'h23, 6'h2B, 6'h0F, 6'h01, 6'h0C, 6'h08};
      instr_valid_i = ($urandom_range(0, 3) != 0);
      pc_i          = {$urandom()} & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) < 7) begin
        opcode_i = legal_ops[$urandom_range(0, 5)];
        funct_i  = 6'($urandom());
      end else begin
        opcode_i = 6'($urandom());
        funct_i  = 6'($urandom());
      end
      eret_i      = ($urandom_range(0, 4) == 0);
      for (int b = 0; b < N; b++) if ($urandom_range(0, 19) == 0) irq_i[b] = ~irq_i[b];
      ack_we_i    = ($urandom_range(0, 9) == 0);
      ack_data_i  = N'($urandom());
      mask_we_i   = ($urandom_range(0, 19) == 0);
      mask_data_i = N'($urandom()) & N'($urandom());
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
